// File: rtl/red_pitaya_pwm_pkg.sv
// Register map, config-word geometry and dither encoder shared by the PWM config generator.
package red_pitaya_pwm_pkg;

  localparam logic [19:0] ADDR_PRESCALE = 20'h00000;
  localparam logic [19:0] ADDR_INFO     = 20'h00004;
  localparam logic [19:0] CH_BASE       = 20'h00040;
  localparam logic [19:0] CH_STRIDE     = 20'h00010;

  localparam logic [3:0] OFF_CTRL = 4'h0;
  localparam logic [3:0] OFF_SET  = 4'h4;
  localparam logic [3:0] OFF_STEP = 4'h8;
  localparam logic [3:0] OFF_CUR  = 4'hC;

  // Encoder works on the widest supported modulation field; callers slice down.
  localparam int MAX_MW = 8;
  localparam int MAX_SL = 1 << MAX_MW;

  function automatic int pwm_sl(input int mw);
    return 1 << mw;
  endfunction

  function automatic int pwm_cw(input int dw, input int mw);
    return dw + pwm_sl(mw);
  endfunction

  // Slot p carries modulation bit MW-1-t, t = trailing ones of p, so the MSB
  // toggles every other slot and each lower bit at half the rate of the one above.
  function automatic logic [MAX_SL-1:0] pwm_dither_enc(input logic [MAX_MW-1:0] m, input int mw);
    logic [MAX_SL-1:0] seq;
    logic [MAX_MW-1:0] sh;
    logic              done;
    int                t;
    seq = '0;
    for (int p = 0; p < MAX_SL; p++) begin
      t    = 0;
      done = 1'b0;
      for (int b = 0; b < MAX_MW; b++) begin
        if (!done && (((p >> b) & 1) == 1)) t++;
        else done = 1'b1;
      end
      sh = m >> (mw - 1 - t);
      if ((p < pwm_sl(mw)) && (t < mw) && sh[0]) seq = seq | (MAX_SL'(1) << p);
    end
    return seq;
  endfunction

endpackage

// File: rtl/red_pitaya_pwm_slew.sv
// One PWM channel: CTRL/SET/STEP registers, slew-limited current value and registered cfg encoder.
// Latency: target -> cur 1 cycle, cur -> cfg 1 cycle; no backpressure.
module red_pitaya_pwm_slew
  import red_pitaya_pwm_pkg::*;
#(
  parameter int  IW = 14,
  parameter int  DW = 8,
  parameter int  MW = 4,
  localparam int SL = pwm_sl(MW),
  localparam int CW = pwm_cw(DW, MW)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 tick,
  input  logic signed [IW-1:0] pwm,
  input  logic [IW-1:0]        wdata,
  input  logic                 wr_ctrl,
  input  logic                 wr_set,
  input  logic                 wr_step,
  output logic [1:0]           ctrl,
  output logic signed [IW-1:0] set_val,
  output logic [IW-1:0]        step,
  output logic signed [IW-1:0] cur,
  output logic [CW-1:0]        cfg
);

  logic                 en;
  logic                 src;
  logic signed [IW-1:0] set_r;
  logic [IW-1:0]        step_r;
  logic signed [IW-1:0] cur_r;
  logic signed [IW-1:0] cur_nxt;
  logic signed [IW-1:0] tgt;
  logic signed [IW:0]   diff;
  logic signed [IW:0]   step_s;
  logic [DW-1:0]        duty;
  logic [MW-1:0]        mod;
  logic [MAX_SL-1:0]    dith_full;
  logic                 unused_dith;

  assign tgt    = src ? pwm : set_r;
  // One guard bit so full-scale swings (e.g. +8191 to -8192) cannot wrap.
  assign diff   = {tgt[IW-1], tgt} - {cur_r[IW-1], cur_r};
  assign step_s = {1'b0, step_r};

  always_comb begin
    cur_nxt = cur_r;
    if (!en) begin
      cur_nxt = '0;
    end else if (step_r == '0) begin
      cur_nxt = tgt;
    end else if (tick) begin
      if (diff > step_s)       cur_nxt = cur_r + step_r;
      else if (diff < -step_s) cur_nxt = cur_r - step_r;
      else                     cur_nxt = tgt;
    end
  end

  assign duty        = {~cur_r[IW-1], cur_r[IW-2 -: DW-1]};
  assign mod         = cur_r[IW-DW-1 -: MW];
  assign dith_full   = pwm_dither_enc(MAX_MW'(mod), MW);
  assign unused_dith = ^dith_full[MAX_SL-1:SL];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en     <= 1'b0;
      src    <= 1'b0;
      set_r  <= '0;
      step_r <= '0;
      cur_r  <= '0;
      cfg    <= '0;
    end else begin
      if (wr_ctrl) {src, en} <= wdata[1:0];
      if (wr_set)  set_r     <= wdata;
      if (wr_step) step_r    <= wdata;
      cur_r <= cur_nxt;
      cfg   <= en ? {duty, dith_full[SL-1:0]} : '0;
    end
  end

  assign ctrl    = {src, en};
  assign set_val = set_r;
  assign step    = step_r;
  assign cur     = cur_r;

endmodule

// File: rtl/red_pitaya_pwm_ctrl.sv
// N-channel PWM-DAC config generator: ramp prescaler, bus decode and per-channel slew/encode.
// Latency: pwm_i -> cfg_o 2 cycles, bus ack 1 cycle; no backpressure (every request acked).
module red_pitaya_pwm_ctrl
  import red_pitaya_pwm_pkg::*;
#(
  parameter int  NCH = 4,
  parameter int  IW  = 14,
  parameter int  DW  = 8,
  parameter int  MW  = 4,
  parameter int  PSW = 16,
  localparam int CW  = pwm_cw(DW, MW)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [NCH*IW-1:0]   pwm_i,
  output logic [NCH*CW-1:0]   cfg_o,
  input  logic [31:0]         sys_addr,
  input  logic [31:0]         sys_wdata,
  input  logic [3:0]          sys_sel,
  input  logic                sys_wen,
  input  logic                sys_ren,
  output logic [31:0]         sys_rdata,
  output logic                sys_err,
  output logic                sys_ack
);

  logic [19:0]          addr;
  logic [19:0]          ch_off;
  logic                 ch_hit;
  logic [15:0]          ch_idx;
  logic [3:0]           ch_reg;
  logic [PSW-1:0]       prescale;
  logic [PSW-1:0]       ps_cnt;
  logic                 ps_wr;
  logic                 tick;
  logic [31:0]          rd;
  logic                 unused_bus;

  logic [1:0]           ctrl_a [NCH];
  logic signed [IW-1:0] set_a  [NCH];
  logic [IW-1:0]        step_a [NCH];
  logic signed [IW-1:0] cur_a  [NCH];

  assign addr       = sys_addr[19:0];
  assign ch_off     = addr - CH_BASE;
  assign ch_hit     = (addr >= CH_BASE) && (ch_off < 20'(NCH) * CH_STRIDE);
  // Channel stride is 16 bytes: upper offset bits select the channel, low nibble the register.
  assign ch_idx     = ch_off[19:4];
  assign ch_reg     = ch_off[3:0];
  assign unused_bus = ^{sys_sel, sys_addr[31:20], sys_wdata};

  assign ps_wr = sys_wen && (addr == ADDR_PRESCALE);
  assign tick  = (ps_cnt == prescale);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic wr_sel;
    assign wr_sel = sys_wen && ch_hit && (ch_idx == 16'(c));

    red_pitaya_pwm_slew #(
      .IW (IW),
      .DW (DW),
      .MW (MW)
    ) u_slew (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .tick    (tick),
      .pwm     (pwm_i[c*IW +: IW]),
      .wdata   (sys_wdata[IW-1:0]),
      .wr_ctrl (wr_sel && (ch_reg == OFF_CTRL)),
      .wr_set  (wr_sel && (ch_reg == OFF_SET)),
      .wr_step (wr_sel && (ch_reg == OFF_STEP)),
      .ctrl    (ctrl_a[c]),
      .set_val (set_a[c]),
      .step    (step_a[c]),
      .cur     (cur_a[c]),
      .cfg     (cfg_o[c*CW +: CW])
    );
  end

  always_comb begin
    rd = '0;
    if (addr == ADDR_PRESCALE) begin
      rd = 32'(prescale);
    end else if (addr == ADDR_INFO) begin
      rd = {8'h0, 8'(NCH), 8'(DW), 8'(MW)};
    end else if (ch_hit) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_idx == 16'(c)) begin
          case (ch_reg)
            OFF_CTRL: rd = {30'b0, ctrl_a[c]};
            OFF_SET:  rd = 32'(set_a[c]);
            OFF_STEP: rd = 32'(step_a[c]);
            OFF_CUR:  rd = 32'(cur_a[c]);
            default:  rd = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prescale  <= '0;
      ps_cnt    <= '0;
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      if (ps_wr) begin
        prescale <= sys_wdata[PSW-1:0];
        ps_cnt   <= '0;
      end else if (tick) begin
        ps_cnt <= '0;
      end else begin
        ps_cnt <= ps_cnt + 1'b1;
      end
      sys_ack   <= sys_wen | sys_ren;
      sys_rdata <= sys_ren ? rd : '0;
    end
  end

  assign sys_err = 1'b0;

endmodule

// File: tb/tb_red_pitaya_pwm_ctrl.sv
// Bench for red_pitaya_pwm_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_red_pitaya_pwm_ctrl;

  localparam int NCH = 4;
  localparam int IW  = 14;
  localparam int CW  = 24;

  logic              clk = 1'b0;
  logic              rstn_i;
  logic [NCH*IW-1:0] pwm_vec = '0;
  logic [NCH*CW-1:0] cfg_o;
  logic [31:0]       sys_addr = '0;
  logic [31:0]       sys_wdata = '0;
  logic [3:0]        sys_sel = 4'hF;
  logic              sys_wen = 1'b0;
  logic              sys_ren = 1'b0;
  logic [31:0]       sys_rdata;
  logic              sys_err;
  logic              sys_ack;

  always #5 clk = ~clk;

  red_pitaya_pwm_ctrl dut (
    .clk_i     (clk),
    .rstn_i    (rstn_i),
    .pwm_i     (pwm_vec),
    .cfg_o     (cfg_o),
    .sys_addr  (sys_addr),
    .sys_wdata (sys_wdata),
    .sys_sel   (sys_sel),
    .sys_wen   (sys_wen),
    .sys_ren   (sys_ren),
    .sys_rdata (sys_rdata),
    .sys_err   (sys_err),
    .sys_ack   (sys_ack)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side state: fabric inputs and the behavioural model.
  int          pwm    [NCH];
  int          m_prescale, m_cnt;
  bit          m_en   [NCH];
  bit          m_src  [NCH];
  int          m_set  [NCH];
  int          m_step [NCH];
  int          m_cur  [NCH];
  logic [23:0] m_cfg  [NCH];
  logic        m_ack;
  logic [31:0] m_rdata;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offset-binary value split into 8-bit duty, 4 modulation bits and a 16-slot dither pattern.
  function automatic logic [23:0] enc(input int cur);
    int u, duty, m, t;
    logic [15:0] seq;
    u    = cur + 8192;
    duty = u / 64;
    m    = (u / 4) % 16;
    seq  = '0;
    for (int p = 0; p < 16; p++) begin
      t = 0;
      while (t < 4 && ((p >> t) & 1) == 1) t++;
      if (t < 4 && ((m >> (3 - t)) & 1) == 1) seq = seq | (16'd1 << p);
    end
    return {8'(duty), seq};
  endfunction

  function automatic int sx14(input logic [31:0] v);
    logic [13:0] s;
    s = v[13:0];
    return int'($signed(s));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int a, c, off;
    a = int'(addr & 32'hFFFFF);
    if (a == 0) return 32'(m_prescale);
    if (a == 4) return 32'h00040804;
    if (a >= 64 && a < 64 + 16 * NCH) begin
      c   = (a - 64) / 16;
      off = (a - 64) % 16;
      case (off)
        0:       return {30'b0, m_src[c], m_en[c]};
        4:       return 32'(m_set[c]);
        8:       return 32'(m_step[c]);
        12:      return 32'(m_cur[c]);
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
    int a, c, off;
    a = int'(addr & 32'hFFFFF);
    if (a == 0) m_prescale = int'(data & 32'hFFFF);
    if (a >= 64 && a < 64 + 16 * NCH) begin
      c   = (a - 64) / 16;
      off = (a - 64) % 16;
      if (off == 0) begin
        m_en[c]  = data[0];
        m_src[c] = data[1];
      end
      if (off == 4) m_set[c]  = sx14(data);
      if (off == 8) m_step[c] = int'(data & 32'h3FFF);
    end
  endtask

  task automatic model_reset();
    m_prescale = 0;
    m_cnt      = 0;
    m_ack      = 1'b0;
    m_rdata    = '0;
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_src[c] = 0; m_set[c] = 0; m_step[c] = 0; m_cur[c] = 0; m_cfg[c] = '0;
    end
  endtask

  // Advance DUT and model by one clock, then compare every output.
  task automatic do_cycle();
    bit               tick;
    int               tgt, cu, st, nc;
    int               n_cur [NCH];
    logic [23:0]      n_cfg [NCH];
    logic [NCH*CW-1:0] exp_cfg;
    for (int c = 0; c < NCH; c++) pwm_vec[c*IW +: IW] = 14'(pwm[c]);
    tick = (m_cnt == m_prescale);
    for (int c = 0; c < NCH; c++) begin
      n_cfg[c] = m_en[c] ? enc(m_cur[c]) : 24'h0;
      tgt = m_src[c] ? pwm[c] : m_set[c];
      cu  = m_cur[c];
      st  = m_step[c];
      nc  = cu;
      if (!m_en[c])     nc = 0;
      else if (st == 0) nc = tgt;
      else if (tick) begin
        if (tgt > cu) nc = (cu + st > tgt) ? tgt : cu + st;
        else          nc = (cu - st < tgt) ? tgt : cu - st;
      end
      n_cur[c] = nc;
    end
    m_ack   = sys_wen | sys_ren;
    m_rdata = sys_ren ? model_read(sys_addr) : 32'h0;
    if (sys_wen && ((sys_addr & 32'hFFFFF) == 0)) m_cnt = 0;
    else if (tick) m_cnt = 0;
    else m_cnt++;
    if (sys_wen) model_write(sys_addr, sys_wdata);
    for (int c = 0; c < NCH; c++) begin
      m_cur[c] = n_cur[c];
      m_cfg[c] = n_cfg[c];
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) exp_cfg[c*CW +: CW] = m_cfg[c];
    check("cfg", 96'(cfg_o), 96'(exp_cfg));
    check("ack", 96'(sys_ack), 96'(m_ack));
    check("rdata", 96'(sys_rdata), 96'(m_rdata));
    check("err", 96'(sys_err), 96'(0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sys_addr  = a;
    sys_wdata = d;
    sys_wen   = 1'b1;
    do_cycle();
    sys_wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    sys_addr = a;
    sys_ren  = 1'b1;
    do_cycle();
    sys_ren  = 1'b0;
    d        = sys_rdata;
  endtask

  logic [31:0] rd;
  logic [31:0] addr_pool [16] = '{32'h0, 32'h4, 32'h8, 32'h3C, 32'h40, 32'h44, 32'h48, 32'h4C,
                                  32'h50, 32'h54, 32'h58, 32'h5C, 32'h64, 32'h78, 32'h80,
                                  32'h8000_0060};
  int          t1_val [4]  = '{0, 8191, -8192, 32};
  logic [23:0] t1_exp [4]  = '{24'h800000, 24'hFF7FFF, 24'h000000, 24'h805555};
  logic [31:0] t3_exp [4]  = '{32'h00001FFF, 32'h00000000, 32'hFFFFE001, 32'hFFFFE000};

  initial begin
    for (int c = 0; c < NCH; c++) pwm[c] = 0;
    model_reset();
    rstn_i = 1'b1;
    #1 rstn_i = 1'b0;
    #2;
    check("rst_cfg", 96'(cfg_o), 96'(0));
    check("rst_ack", 96'(sys_ack), 96'(0));
    check("rst_rdata", 96'(sys_rdata), 96'(0));
    #10 rstn_i = 1'b1;

    // Fabric values on ch0 with STEP=0 reach cfg_o after two cycles.
    bus_write(32'h40, 32'h3);
    for (int i = 0; i < 4; i++) begin
      pwm[0] = t1_val[i];
      do_cycle();
      do_cycle();
      check("t1_cfg", 96'(cfg_o[23:0]), 96'(t1_exp[i]));
    end

    bus_read(32'h04, rd);
    check("info", 96'(rd), 96'(32'h00040804));
    bus_read(32'h3C, rd);
    check("unmapped_rd", 96'(rd), 96'(0));
    check("unmapped_ack", 96'(sys_ack), 96'(1));
    idle(1);
    check("no_req_ack", 96'(sys_ack), 96'(0));

    // Prescaled ramp on ch1.
    bus_write(32'h58, 32'd100);
    bus_write(32'h54, 32'd1000);
    bus_write(32'h00, 32'd9);
    bus_write(32'h50, 32'h1);
    for (int i = 0; i < 12; i++) begin
      idle(9);
      bus_read(32'h5C, rd);
    end
    bus_read(32'h5C, rd);
    check("t2_cur1000", 96'(rd), 96'(32'd1000));
    bus_write(32'h54, 32'd1050);
    idle(20);
    bus_read(32'h5C, rd);
    check("t2_cur1050", 96'(rd), 96'(32'd1050));

    // Full-scale swing on ch2 with a tick every cycle.
    bus_write(32'h00, 32'd0);
    bus_write(32'h68, 32'd0);
    bus_write(32'h64, 32'd8191);
    bus_write(32'h60, 32'h1);
    idle(2);
    bus_write(32'h68, 32'd8191);
    bus_write(32'h64, 32'hFFFFE000);
    for (int i = 0; i < 4; i++) begin
      bus_read(32'h6C, rd);
      check("t3_cur", 96'(rd), 96'(t3_exp[i]));
    end

    // SET write coincident with a tick on ch3.
    bus_write(32'h78, 32'd10);
    bus_write(32'h74, 32'd100);
    bus_write(32'h70, 32'h1);
    idle(15);
    bus_write(32'h74, 32'd0);
    bus_read(32'h7C, rd);
    check("t6_old_set", 96'(rd), 96'(32'd100));
    bus_read(32'h7C, rd);
    check("t6_new_set", 96'(rd), 96'(32'd90));

    // Disable mid-ramp, re-enable, then async reset mid-ramp.
    bus_write(32'h00, 32'd9);
    bus_write(32'h54, 32'hFFFFEC78);
    idle(35);
    bus_write(32'h50, 32'h0);
    do_cycle();
    check("t4_cfg_off", 96'(cfg_o[47:24]), 96'(0));
    bus_read(32'h5C, rd);
    check("t4_cur_off", 96'(rd), 96'(0));
    bus_write(32'h50, 32'h1);
    idle(25);
    bus_read(32'h5C, rd);
    #2 rstn_i = 1'b0;
    #1;
    check("t4_arst_cfg", 96'(cfg_o), 96'(0));
    check("t4_arst_ack", 96'(sys_ack), 96'(0));
    check("t4_arst_rdata", 96'(sys_rdata), 96'(0));
    model_reset();
    #3 rstn_i = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      int op, la;
      logic [31:0] a, d;
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0) pwm[c] = int'($urandom_range(0, 16383)) - 8192;
      op = int'($urandom_range(0, 9));
      a  = addr_pool[$urandom_range(0, 15)];
      la = int'(a & 32'hFFFFF);
      d  = $urandom;
      if (la == 0) d = 32'($urandom_range(0, 3));
      if (la >= 64 && (la % 16) == 8) d = ($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom_range(1, 3000));
      if (la >= 64 && (la % 16) == 0) d = 32'($urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, 3));
      if (op < 3) begin
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
      end else if (op < 6) begin
        sys_addr = a; sys_ren = 1'b1;
      end
      do_cycle();
      sys_wen = 1'b0;
      sys_ren = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
